// File: rtl/memory_cycle.sv
// Memory stage of the RV32I pipeline: issues load/store on a req/ack bus,
// extracts and extends load data, and fills the M/W pipeline register.
module memory_cycle #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic        MisalignW,
    output logic        BusErrW
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [1:0]     off_q;
    logic [2:0]     f3_q;
    logic           ld_q;

    logic           memop;
    logic           bad;
    logic           timeout;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c;
    logic [15:0]    lane;
    logic [31:0]    load_data;

    assign memop   = ValidM & (MemWriteM | ResultSrcM);
    assign timeout = (cnt == CW'(TIMEOUT - 1));
    assign StallM  = (state == IDLE) ? (memop & ~bad) : (~dmem_ack & ~timeout);

    // Size/alignment legality of the requested access
    always_comb begin
        bad = 1'b1;
        case (Funct3M)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = ALUResultM[0];
            3'b010:         bad = |ALUResultM[1:0];
            default:        bad = 1'b1;
        endcase
    end

    // Store lane steering; reads enable all lanes
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = 32'h0;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << ALUResultM[1:0];
                    wdata_c = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = WriteDataM;
                end
            endcase
        end
    end

    // Load byte/half extraction with sign or zero extension
    always_comb begin
        lane      = 16'(dmem_rdata >> {off_q, 3'b000});
        load_data = dmem_rdata;
        case (f3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane};
            3'b100:  load_data = {24'h0, lane[7:0]};
            3'b101:  load_data = {16'h0, lane};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            ld_q       <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            ValidW     <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RdW        <= 5'h0;
            PCPlus4W   <= 32'h0;
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (memop && !bad) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= {ALUResultM[31:2], 2'b00};
                        dmem_be    <= be_c;
                        dmem_wdata <= wdata_c;
                        off_q      <= ALUResultM[1:0];
                        f3_q       <= Funct3M;
                        ld_q       <= ResultSrcM;
                        ValidW     <= 1'b0;
                        RegWriteW  <= 1'b0;
                        ResultSrcW <= 1'b0;
                        ReadDataW  <= 32'h0;
                        state      <= BUSY;
                    end else begin
                        // Plain pass-through, or a retired misaligned access
                        ValidW     <= memop | ValidM;
                        RegWriteW  <= memop ? 1'b0 : RegWriteM;
                        ResultSrcW <= ResultSrcM;
                        RdW        <= RdM;
                        PCPlus4W   <= PCPlus4M;
                        ALUResultW <= ALUResultM;
                        ReadDataW  <= 32'h0;
                        MisalignW  <= memop;
                    end
                end
                BUSY: begin
                    if (dmem_ack || timeout) begin
                        // Ack wins over a coincident timeout
                        dmem_req   <= 1'b0;
                        ValidW     <= 1'b1;
                        RegWriteW  <= dmem_ack & RegWriteM;
                        ResultSrcW <= ResultSrcM;
                        RdW        <= RdM;
                        PCPlus4W   <= PCPlus4M;
                        ALUResultW <= ALUResultM;
                        ReadDataW  <= (dmem_ack && ld_q) ? load_data : 32'h0;
                        BusErrW    <= ~dmem_ack;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed scenarios then randomized accesses
// checked against an arithmetic model of the access rules.
module tb_memory_cycle;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, MemWriteM, ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M, ALUResultM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        StallM, ValidW, RegWriteW, ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W, ALUResultW, ReadDataW;
    logic        MisalignW, BusErrW;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .StallM(StallM), .ValidW(ValidW),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .PCPlus4W(PCPlus4W), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access width in bytes; 0 means illegal encoding
    function automatic int unsigned ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic ref_bad(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = ref_size(f3);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = ref_size(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (ref_size(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
        int unsigned sh = rd >> (8 * (a % 4));
        int unsigned b  = sh % 256;
        int unsigned h  = sh % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // One instruction through M; delay = wait cycles before ack (>= TIMEOUT: never acked)
    task automatic run_op(input string tag, input logic v, input logic rw, input logic mw,
                          input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdat, input int delay);
        logic memop, bad, ok, done;
        logic [31:0] pc4;
        pc4        = $urandom;
        memop      = v && (mw || ld);
        bad        = ref_bad(f3, addr);
        ValidM     = v;
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = ld;
        Funct3M    = f3;
        RdM        = rd;
        PCPlus4M   = pc4;
        ALUResultM = addr;
        WriteDataM = wd;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        chk({tag, ".stall_idle"}, 32'(StallM), 32'(memop && !bad));
        tick();
        if (!memop || bad) begin
            chk({tag, ".validw"}, 32'(ValidW), 32'(memop ? 1'b1 : v));
            chk({tag, ".regw"}, 32'(RegWriteW), 32'(memop ? 1'b0 : rw));
            chk({tag, ".rdw"}, 32'(RdW), 32'(rd));
            chk({tag, ".aluw"}, ALUResultW, addr);
            chk({tag, ".pc4w"}, PCPlus4W, pc4);
            chk({tag, ".misalign"}, 32'(MisalignW), 32'(memop));
            chk({tag, ".buserr"}, 32'(BusErrW), 32'h0);
            chk({tag, ".noreq"}, 32'(dmem_req), 32'h0);
        end else begin
            chk({tag, ".req"}, 32'(dmem_req), 32'h1);
            chk({tag, ".we"}, 32'(dmem_we), 32'(mw));
            chk({tag, ".addr"}, dmem_addr, addr - (addr % 4));
            chk({tag, ".be"}, 32'(dmem_be), 32'(mw ? ref_be(f3, addr) : 4'hF));
            if (mw) chk({tag, ".wdata"}, dmem_wdata, ref_wdata(f3, wd));
            chk({tag, ".bubble"}, 32'({ValidW, RegWriteW, MisalignW, BusErrW}), 32'h0);
            done = 1'b0;
            for (int k = 0; k < int'(TIMEOUT) && !done; k++) begin
                dmem_ack   = (k == delay);
                dmem_rdata = rdat;
                #1;
                chk({tag, ".stall_busy"}, 32'(StallM), 32'((k != delay) && (k != int'(TIMEOUT) - 1)));
                tick();
                if (k == delay || k == int'(TIMEOUT) - 1) begin
                    done = 1'b1;
                end else begin
                    chk({tag, ".hold_req"}, 32'(dmem_req), 32'h1);
                    chk({tag, ".hold_bubble"}, 32'(ValidW), 32'h0);
                end
            end
            dmem_ack = 1'b0;
            ok = delay < int'(TIMEOUT);
            chk({tag, ".req_drop"}, 32'(dmem_req), 32'h0);
            chk({tag, ".validw"}, 32'(ValidW), 32'h1);
            chk({tag, ".regw"}, 32'(RegWriteW), 32'(ok && rw));
            chk({tag, ".buserr"}, 32'(BusErrW), 32'(!ok));
            chk({tag, ".misalign"}, 32'(MisalignW), 32'h0);
            chk({tag, ".rdw"}, 32'(RdW), 32'(rd));
            chk({tag, ".aluw"}, ALUResultW, addr);
            if (ok && ld) chk({tag, ".rdata"}, ReadDataW, ref_load(f3, addr, rdat));
        end
    endtask

    initial begin
        logic [2:0]  legal [5];
        logic [2:0]  f3;
        logic [31:0] a, d, r;
        int          kind, dly;
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;

        rst = 1'b1;
        ValidM = 0; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; Funct3M = 0; RdM = 0;
        PCPlus4M = 0; ALUResultM = 0; WriteDataM = 0; dmem_ack = 0; dmem_rdata = 0;
        tick();
        tick();
        chk("reset.req", 32'(dmem_req), 32'h0);
        chk("reset.w", 32'({ValidW, RegWriteW, ResultSrcW, MisalignW, BusErrW}), 32'h0);
        chk("reset.data", ALUResultW | ReadDataW | PCPlus4W | dmem_addr, 32'h0);
        chk("reset.stall", 32'(StallM), 32'h0);
        rst = 1'b0;

        run_op("alu", 1, 1, 0, 0, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 0);
        run_op("lb_wait3", 1, 1, 0, 1, 3'd0, 5'd7, 32'h103, 32'h0, 32'h80FF_FF00, 3);
        run_op("sh", 1, 0, 1, 0, 3'd1, 5'd0, 32'h202, 32'hABCD_1234, 32'h0, 0);
        run_op("lw_misal", 1, 1, 0, 1, 3'd2, 5'd9, 32'h106, 32'h0, 32'h0, 0);
        run_op("lw_timeout", 1, 1, 0, 1, 3'd2, 5'd3, 32'h400, 32'h0, 32'h0, 99);
        run_op("after_to", 1, 1, 0, 0, 3'd0, 5'd4, 32'h55, 32'h0, 32'h0, 0);
        run_op("ack_at_to", 1, 1, 0, 1, 3'd5, 5'd6, 32'h802, 32'h0, 32'h8765_4321,
               int'(TIMEOUT) - 1);
        run_op("illegal_f3", 1, 0, 1, 0, 3'd7, 5'd1, 32'h0, 32'h0, 32'h0, 0);

        // Reset during the second BUSY cycle with a coincident ack
        ValidM = 1; RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; Funct3M = 3'd2;
        RdM = 5'd8; ALUResultM = 32'h100; dmem_ack = 0;
        tick();
        tick();
        rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rst_busy.req", 32'(dmem_req), 32'h0);
        chk("rst_busy.validw", 32'(ValidW), 32'h0);
        chk("rst_busy.rdata", ReadDataW, 32'h0);
        rst = 1'b0; dmem_ack = 1'b0;
        run_op("rst_busy.idle", 1, 1, 0, 0, 3'd0, 5'd2, 32'h77, 32'h0, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                               : legal[$urandom_range(0, 4)];
            a    = $urandom;
            if ($urandom_range(0, 2) != 0) a = a - (a % (ref_size(f3) == 0 ? 1 : ref_size(f3)));
            d    = $urandom;
            r    = $urandom;
            case ($urandom_range(0, 9))
                0:       dly = int'(TIMEOUT) + 2;
                1:       dly = int'(TIMEOUT) - 1;
                default: dly = $urandom_range(0, 4);
            endcase
            run_op("rand", ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                   kind == 2, kind == 1, f3, 5'($urandom), a, d, r, dly);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
